ro_mailbox: RTL and testbench
=============================

Name: ro_mailbox

Overview:
- Parametrised PS/PL mailbox between the processing-system block design and the ring-oscillator measurement core. It replaces the fixed 7-in/3-out, 32-bit serial word interface with configurable channel counts and word width.
- Command side: each PS interrupt edge captures that channel's word and emits a one-cycle command strobe to PL logic.
- Result side: PL result words are buffered in a FIFO. A dispatcher presents them to the PS one at a time, with an interrupt/acknowledge handshake per output channel.
- DECOUPLE support lets partial reconfiguration proceed safely.

Parameters:
- NUM_IN, 7, number of PS-to-PL command channels.
- NUM_OUT, 3, number of PL-to-PS result channels.
- DATA_W, 32, word width per channel.
- FIFO_DEPTH, 16, result FIFO entries; power of two, at least 2.
- CH_W, max(1,$clog2(NUM_OUT)), width of the result channel index (derived localparam).

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DECOUPLE  in  1  high = PS side isolated; freezes the handshake.
- intr_in  in  NUM_IN  PS command interrupt lines (level; rising edge = new command).
- data_in  in  NUM_IN*DATA_W  packed command words; channel i is bits [i*DATA_W +: DATA_W].
- cmd_valid  out  NUM_IN  one-cycle strobe per captured command.
- cmd_data  out  NUM_IN*DATA_W  captured command words, held until the next capture on that channel.
- res_valid  in  1  result push request.
- res_ready  out  1  FIFO can accept (= !full).
- res_chan  in  CH_W  destination output channel.
- res_data  in  DATA_W  result word.
- intr_out  out  NUM_OUT  PS result interrupt lines (level).
- intr_ack  in  NUM_OUT  PS acknowledge lines (level; rising edge = ack).
- data_out  out  NUM_OUT*DATA_W  packed result words; channel j is bits [j*DATA_W +: DATA_W].
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_chan  out  1  sticky flag: a push was made with res_chan >= NUM_OUT.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, edge-detect history registers 0.
- Command capture:
  - Edge on channel i = intr_in[i] & ~prev_in[i] & ~DECOUPLE, where prev_in is updated every cycle, including during DECOUPLE.
  - Edge in cycle t gives cmd_valid[i]=1 and cmd_data slice i = data_in slice i at cycle t+1. Latency is 1 cycle.
  - Edges on several channels in the same cycle are all captured in parallel.
  - There is no backpressure; a new edge overwrites cmd_data.
  - A level held high across the end of DECOUPLE does not produce an edge.
- Result FIFO:
  - Push when res_valid & res_ready. Each entry is {res_chan, res_data}.
  - Full: res_ready=0 and nothing is dropped.
  - Simultaneous push and pop while full or empty is legal: when empty, push only; when full, pop frees a slot and res_ready rises the next cycle.
  - fifo_level updates one cycle after the push/pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - If res_chan >= NUM_OUT, the push is accepted and discarded at dispatch (no interrupt), and err_chan is set. err_chan clears only on RESET.
- Dispatch FSM (ack edge = intr_ack & ~prev_ack):
  - IDLE: if FIFO not empty and !DECOUPLE, pop the head, write data_out slice[chan] and latch cur_chan, then go to ARM. Other data_out slices hold their values.
  - ARM: intr_out[cur_chan]=1 from the next cycle; go to WAIT_ACK. For an invalid chan, go directly to IDLE.
  - WAIT_ACK: on an ack edge on cur_chan, intr_out[cur_chan]=0 the next cycle; go to RELEASE. Acks on other channels are ignored.
  - RELEASE: wait until intr_ack[cur_chan]=0, then go to IDLE.
- Timing:
  - Minimum pop-to-interrupt latency is 2 cycles.
  - At most one intr_out bit is high at any time.
- DECOUPLE high:
  - intr_out is forced to 0 combinationally from registered state.
  - The FSM holds its state, and no pop occurs.
  - The FIFO still accepts pushes.
  - On release, the FSM resumes, and intr_out is re-asserted if the FSM is in WAIT_ACK.
- RESET mid-handshake: everything clears within 1 cycle, and FIFO contents are lost.

Decomposition:
- Package ro_mailbox_pkg holds:
  - FSM state encoding (IDLE, ARM, WAIT_ACK, RELEASE);
  - the CH_W computation function;
  - DATA_W default.
- Sub-module ro_mailbox_fifo: synchronous FIFO with parameters width CH_W+DATA_W and FIFO_DEPTH; provides full, empty and level.
- Slice pack/unpack uses the existing portarray pack/unpack macros.

Test Plan:
- Command capture: after reset, pulse intr_in[3] with data_in slice3=32'hDEADBEEF, and assert intr_in[0] in the same cycle -> cmd_valid=7'b0001001 one cycle later, with the slice 3 and slice 0 words captured. Holding intr_in high produces no further strobe.
- Single result: push chan=2, data=32'h12345678 -> intr_out=3'b100 two cycles after the pop, data_out slice2 = 32'h12345678. Raise intr_ack[2] -> intr_out=0 the next cycle. Drop ack -> FSM returns to IDLE.
- Back-to-back results: push 16 words round-robin over channels 0..2 with no waits -> res_ready=0 after the 16th push (fifo_level=16), the 17th push stalls, and the PS side acks each word. Results are delivered in order with exactly one intr_out bit high at a time.
- Decouple: assert DECOUPLE during WAIT_ACK -> intr_out=0 and the state is held. Pulse intr_in[1] during decouple -> no cmd_valid. Deassert DECOUPLE -> intr_out re-asserts, and an ack completes the transfer.
- Invalid channel: push chan=3 with NUM_OUT=3 -> err_chan=1 and no interrupt. The following valid entry is dispatched normally.
- Reset mid-operation: assert RESET while in WAIT_ACK with 5 entries queued -> the next cycle shows intr_out=0, fifo_level=0, res_ready=1 and err_chan=0.

Source files
------------

// File: rtl/ro_mailbox_pkg.sv
// Shared definitions for the ring-oscillator PS/PL mailbox: dispatch FSM
// encoding, default word width and the result-channel index width helper.
package ro_mailbox_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARM      = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Index width for n channels, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_mailbox_fifo.sv
// Synchronous result FIFO: writes are ignored when full, reads when empty.
// The head entry is presented combinationally on rdata.
module ro_mailbox_fifo #(
    parameter int  WIDTH = 34,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == '0);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array, no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/ro_mailbox.sv
// PS/PL mailbox: edge-triggered command capture towards the PL and a FIFO-fed
// interrupt/acknowledge dispatcher carrying result words back to the PS.
module ro_mailbox
    import ro_mailbox_pkg::*;
#(
    parameter int  NUM_IN     = 7,
    parameter int  NUM_OUT    = 3,
    parameter int  DATA_W     = DATA_W_DEFAULT,
    parameter int  FIFO_DEPTH = 16,
    localparam int CH_W       = ch_width(NUM_OUT),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      DECOUPLE,
    input  logic [NUM_IN-1:0]         intr_in,
    input  logic [NUM_IN*DATA_W-1:0]  data_in,
    output logic [NUM_IN-1:0]         cmd_valid,
    output logic [NUM_IN*DATA_W-1:0]  cmd_data,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [CH_W-1:0]           res_chan,
    input  logic [DATA_W-1:0]         res_data,
    output logic [NUM_OUT-1:0]        intr_out,
    input  logic [NUM_OUT-1:0]        intr_ack,
    output logic [NUM_OUT*DATA_W-1:0] data_out,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      err_chan
);

    localparam logic [CH_W:0] NUM_OUT_V = NUM_OUT[CH_W:0];

    logic [NUM_IN-1:0]       prev_in_r;
    logic [NUM_IN-1:0]       cmd_edge_s;
    logic [NUM_OUT-1:0]      prev_ack_r;
    logic [NUM_OUT-1:0]      ack_edge_s;
    logic [NUM_OUT-1:0]      intr_r;
    logic [NUM_OUT-1:0]      cur_sel_s;
    logic [NUM_OUT-1:0]      head_sel_s;
    logic [1:0]              state_r;
    logic [CH_W-1:0]         cur_chan_r;
    logic                    chan_ok_r;
    logic [CH_W+DATA_W-1:0]  head_s;
    logic [CH_W-1:0]         head_chan_s;
    logic [DATA_W-1:0]       head_data_s;
    logic                    head_ok_s;
    logic                    res_ok_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    pop_s;

    // History keeps tracking during DECOUPLE so a held level cannot fake an edge.
    assign cmd_edge_s  = intr_in & ~prev_in_r & {NUM_IN{~DECOUPLE}};
    assign ack_edge_s  = intr_ack & ~prev_ack_r;
    assign head_chan_s = head_s[DATA_W +: CH_W];
    assign head_data_s = head_s[DATA_W-1:0];
    assign head_ok_s   = ({1'b0, head_chan_s} < NUM_OUT_V);
    assign res_ok_s    = ({1'b0, res_chan} < NUM_OUT_V);
    assign res_ready   = ~full_s;
    assign pop_s       = (state_r == ST_IDLE) & ~empty_s & ~DECOUPLE;
    assign intr_out    = DECOUPLE ? '0 : intr_r;

    ro_mailbox_fifo #(
        .WIDTH (CH_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (res_valid),
        .pop   (pop_s),
        .wdata ({res_chan, res_data}),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level)
    );

    // One-hot decode of the current and head channel indices.
    always_comb begin
        cur_sel_s  = '0;
        head_sel_s = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            cur_sel_s[j]  = (cur_chan_r == CH_W'(j));
            head_sel_s[j] = (head_chan_s == CH_W'(j));
        end
    end

    // Command capture: one-cycle strobe and word latch per rising edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_in_r <= '0;
            cmd_valid <= '0;
            cmd_data  <= '0;
        end else begin
            prev_in_r <= intr_in;
            cmd_valid <= cmd_edge_s;
            for (int i = 0; i < NUM_IN; i++) begin
                if (cmd_edge_s[i]) begin
                    cmd_data[i*DATA_W +: DATA_W] <= data_in[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Sticky flag for pushes addressed to a channel that does not exist.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_chan <= 1'b0;
        end else if (res_valid && !full_s && !res_ok_s) begin
            err_chan <= 1'b1;
        end else begin
            err_chan <= err_chan;
        end
    end

    // Dispatch FSM; frozen entirely while DECOUPLE is high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            cur_chan_r <= '0;
            chan_ok_r  <= 1'b0;
            intr_r     <= '0;
            prev_ack_r <= '0;
            data_out   <= '0;
        end else begin
            prev_ack_r <= intr_ack;
            if (!DECOUPLE) begin
                case (state_r)
                    ST_IDLE: begin
                        if (pop_s) begin
                            cur_chan_r <= head_chan_s;
                            chan_ok_r  <= head_ok_s;
                            for (int j = 0; j < NUM_OUT; j++) begin
                                if (head_sel_s[j]) begin
                                    data_out[j*DATA_W +: DATA_W] <= head_data_s;
                                end
                            end
                            state_r <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (chan_ok_r) begin
                            intr_r  <= cur_sel_s;
                            state_r <= ST_WAIT_ACK;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (|(ack_edge_s & cur_sel_s)) begin
                            intr_r  <= '0;
                            state_r <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (!(|(intr_ack & cur_sel_s))) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        intr_r  <= '0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ro_mailbox.sv
// Directed bench for ro_mailbox with default parameters (7 in, 3 out, 32-bit, depth 16).
module tb_ro_mailbox;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         DECOUPLE;
    logic [6:0]   intr_in;
    logic [223:0] data_in;
    logic [6:0]   cmd_valid;
    logic [223:0] cmd_data;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_chan;
    logic [31:0]  res_data;
    logic [2:0]   intr_out;
    logic [2:0]   intr_ack;
    logic [95:0]  data_out;
    logic [4:0]   fifo_level;
    logic         err_chan;

    int tests  = 0;
    int failed = 0;

    ro_mailbox dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DECOUPLE   (DECOUPLE),
        .intr_in    (intr_in),
        .data_in    (data_in),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_chan   (res_chan),
        .res_data   (res_data),
        .intr_out   (intr_out),
        .intr_ack   (intr_ack),
        .data_out   (data_out),
        .fifo_level (fifo_level),
        .err_chan   (err_chan)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_intr(input string name);
        int n = 0;
        while (intr_out == 3'b000 && n < 20) begin
            tick(1);
            n++;
        end
        tests++;
        if (n >= 20) begin
            failed++;
            $display("FAIL %s timeout: intr_out=%b after %0d cycles, required nonzero", name, intr_out, n);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; DECOUPLE = 1'b0; intr_in = '0; data_in = '0;
        res_valid = 1'b0; res_chan = '0; res_data = '0; intr_ack = '0;
        tick(2);
        RESET = 1'b0;
        tests++;
        if ({cmd_valid, intr_out, fifo_level, res_ready, err_chan} !== {7'd0, 3'd0, 5'd0, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL reset_state: cv=%b io=%b lvl=%0d rdy=%b err=%b, required 0/0/0/1/0",
                     cmd_valid, intr_out, fifo_level, res_ready, err_chan);
        end
        tests++;
        if (data_out !== 96'd0 || cmd_data !== 224'd0) begin
            failed++;
            $display("FAIL reset_data: data_out=%h cmd_data=%h, required 0", data_out, cmd_data);
        end
    endtask

    task automatic test_cmd_capture();
        data_in[3*32 +: 32] = 32'hDEADBEEF;
        data_in[0*32 +: 32] = 32'hA5A50001;
        intr_in = 7'b0001001;
        tick(1);
        tests++;
        if (cmd_valid !== 7'b0001001) begin
            failed++;
            $display("FAIL cmd_strobe: cmd_valid=%b, required 0001001", cmd_valid);
        end
        tests++;
        if (cmd_data[3*32 +: 32] !== 32'hDEADBEEF || cmd_data[0 +: 32] !== 32'hA5A50001) begin
            failed++;
            $display("FAIL cmd_data: s3=%h s0=%h, required deadbeef a5a50001",
                     cmd_data[3*32 +: 32], cmd_data[0 +: 32]);
        end
        data_in[3*32 +: 32] = 32'h0;
        tick(1);
        tests++;
        if (cmd_valid !== 7'b0 || cmd_data[3*32 +: 32] !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL cmd_hold: cmd_valid=%b s3=%h, required 0 deadbeef", cmd_valid, cmd_data[3*32 +: 32]);
        end
        intr_in = '0;
        tick(1);
    endtask

    task automatic test_single_result();
        res_chan = 2'd2; res_data = 32'h12345678; res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        tests++;
        if (fifo_level !== 5'd1) begin
            failed++;
            $display("FAIL single_level: fifo_level=%0d, required 1", fifo_level);
        end
        tick(1);
        tests++;
        if (intr_out !== 3'b000 || fifo_level !== 5'd0 || data_out[2*32 +: 32] !== 32'h12345678) begin
            failed++;
            $display("FAIL single_pop: io=%b lvl=%0d s2=%h, required 000 0 12345678",
                     intr_out, fifo_level, data_out[2*32 +: 32]);
        end
        tick(1);
        tests++;
        if (intr_out !== 3'b100) begin
            failed++;
            $display("FAIL single_intr: intr_out=%b, required 100", intr_out);
        end
        intr_ack = 3'b100;
        tick(1);
        tests++;
        if (intr_out !== 3'b000) begin
            failed++;
            $display("FAIL single_ack: intr_out=%b, required 000", intr_out);
        end
        tick(2);
        tests++;
        if (intr_out !== 3'b000) begin
            failed++;
            $display("FAIL single_release: intr_out=%b, required 000", intr_out);
        end
        intr_ack = 3'b000;
        tick(1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_io;
        int ch;
        DECOUPLE = 1'b1;
        for (int k = 0; k < 16; k++) begin
            res_chan = 2'(k % 3); res_data = 32'hB0000000 + 32'(k); res_valid = 1'b1;
            tick(1);
        end
        tests++;
        if (fifo_level !== 5'd16 || res_ready !== 1'b0) begin
            failed++;
            $display("FAIL b2b_full: lvl=%0d rdy=%b, required 16 0", fifo_level, res_ready);
        end
        res_chan = 2'd0; res_data = 32'hDEADDEAD;
        tick(1);
        res_valid = 1'b0;
        tests++;
        if (fifo_level !== 5'd16) begin
            failed++;
            $display("FAIL b2b_stall: lvl=%0d, required 16", fifo_level);
        end
        DECOUPLE = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ch = k % 3;
            exp_io = 3'b001 << ch;
            wait_intr("b2b_wait");
            tests++;
            if (intr_out !== exp_io || data_out[ch*32 +: 32] !== 32'hB0000000 + 32'(k)) begin
                failed++;
                $display("FAIL b2b_word%0d: io=%b data=%h, required %b %h",
                         k, intr_out, data_out[ch*32 +: 32], exp_io, 32'hB0000000 + 32'(k));
            end
            if (k == 0) begin
                tests++;
                if (res_ready !== 1'b1 || fifo_level !== 5'd15) begin
                    failed++;
                    $display("FAIL b2b_free: rdy=%b lvl=%0d, required 1 15", res_ready, fifo_level);
                end
                intr_ack = 3'b001 << ((ch + 1) % 3);
                tick(1);
                tests++;
                if (intr_out !== exp_io) begin
                    failed++;
                    $display("FAIL b2b_wrong_ack: io=%b, required %b", intr_out, exp_io);
                end
                intr_ack = 3'b000;
                tick(1);
            end
            intr_ack = exp_io;
            tick(1);
            intr_ack = 3'b000;
            tick(1);
        end
        tick(3);
        tests++;
        if (fifo_level !== 5'd0 || intr_out !== 3'b000) begin
            failed++;
            $display("FAIL b2b_drain: lvl=%0d io=%b, required 0 000", fifo_level, intr_out);
        end
    endtask

    task automatic test_decouple();
        res_chan = 2'd1; res_data = 32'h0D0D0001; res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        wait_intr("dec_wait");
        DECOUPLE = 1'b1;
        #1;
        tests++;
        if (intr_out !== 3'b000) begin
            failed++;
            $display("FAIL dec_force: intr_out=%b, required 000", intr_out);
        end
        data_in[1*32 +: 32] = 32'h11111111;
        intr_in = 7'b0000010;
        tick(1);
        tests++;
        if (cmd_valid !== 7'b0) begin
            failed++;
            $display("FAIL dec_cmd: cmd_valid=%b, required 0", cmd_valid);
        end
        intr_in = '0;
        tick(2);
        tests++;
        if (intr_out !== 3'b000 || cmd_data[1*32 +: 32] !== 32'h0) begin
            failed++;
            $display("FAIL dec_hold: io=%b s1=%h, required 000 0", intr_out, cmd_data[1*32 +: 32]);
        end
        DECOUPLE = 1'b0;
        #1;
        tests++;
        if (intr_out !== 3'b010 || data_out[1*32 +: 32] !== 32'h0D0D0001) begin
            failed++;
            $display("FAIL dec_resume: io=%b s1=%h, required 010 0d0d0001", intr_out, data_out[1*32 +: 32]);
        end
        intr_ack = 3'b010;
        tick(1);
        tests++;
        if (intr_out !== 3'b000) begin
            failed++;
            $display("FAIL dec_ack: intr_out=%b, required 000", intr_out);
        end
        intr_ack = 3'b000;
        tick(1);
    endtask

    task automatic test_invalid_chan();
        res_chan = 2'd3; res_data = 32'hBAD0BAD0; res_valid = 1'b1;
        tick(1);
        tests++;
        if (err_chan !== 1'b1) begin
            failed++;
            $display("FAIL inv_err: err_chan=%b, required 1", err_chan);
        end
        res_chan = 2'd0; res_data = 32'hC0C0C0C0;
        tick(1);
        res_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick(1);
            tests++;
            if (intr_out !== 3'b000) begin
                failed++;
                $display("FAIL inv_no_intr%0d: intr_out=%b, required 000", k, intr_out);
            end
        end
        wait_intr("inv_wait");
        tests++;
        if (intr_out !== 3'b001 || data_out !== {32'hB000000E, 32'h0D0D0001, 32'hC0C0C0C0}) begin
            failed++;
            $display("FAIL inv_next: io=%b data_out=%h, required 001 b000000e0d0d0001c0c0c0c0", intr_out, data_out);
        end
        intr_ack = 3'b001;
        tick(1);
        intr_ack = 3'b000;
        tick(1);
        tests++;
        if (err_chan !== 1'b1) begin
            failed++;
            $display("FAIL inv_sticky: err_chan=%b, required 1", err_chan);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 6; k++) begin
            res_chan = 2'd0; res_data = 32'hE0000000 + 32'(k); res_valid = 1'b1;
            tick(1);
        end
        res_valid = 1'b0;
        wait_intr("rst_wait");
        tests++;
        if (fifo_level !== 5'd5 || intr_out !== 3'b001) begin
            failed++;
            $display("FAIL rst_pre: lvl=%0d io=%b, required 5 001", fifo_level, intr_out);
        end
        RESET = 1'b1;
        tick(1);
        tests++;
        if ({intr_out, fifo_level, res_ready, err_chan} !== {3'd0, 5'd0, 1'b1, 1'b0} || data_out !== 96'd0) begin
            failed++;
            $display("FAIL rst_mid: io=%b lvl=%0d rdy=%b err=%b data_out=%h, required 000 0 1 0 0",
                     intr_out, fifo_level, res_ready, err_chan, data_out);
        end
        RESET = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_cmd_capture();
        test_single_result();
        test_back_to_back();
        test_decouple();
        test_invalid_chan();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
